fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8: program counter and ROM address width.
REQ-002 SHALL have parameter INSTR_WIDTH, default 12: instruction word width.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port nReset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port RomAddr  output  PC_WIDTH  program ROM address, equal to the PC register.
REQ-006 SHALL have port RomData  input  INSTR_WIDTH  combinational program ROM read data for RomAddr.
REQ-007 SHALL have port PCHold  input  1  hold request from the control stage.
REQ-008 SHALL have port HandshakeAsync  input  1  unsynchronised external handshake.
REQ-009 SHALL have port Handshake  output  1  synchronised handshake, fed to the control stage.
REQ-010 SHALL have port Instruction  output  INSTR_WIDTH  instruction register (IR) contents.
REQ-011 SHALL have port Stage  output  2  current stage, 0..3.
REQ-012 SHALL have port Branch  input  1  branch request (present only with FETCH_BRANCH_EN).
REQ-013 SHALL have port BranchOffset  input  8  signed two's-complement branch offset (present only with FETCH_BRANCH_EN).

Function
REQ-014 Stage SHALL step 0->1->2->3->0, one step per clock.
REQ-015 In stage 3 with PCHold=1, Stage SHALL remain 3, and PC and IR SHALL remain unchanged.
REQ-016 At the edge ending stage 0, IR SHALL load RomData; Instruction is therefore valid during stages 1-3, one clock after fetch.
REQ-017 At the edge ending stage 3 with PCHold=0, PC SHALL become PC+1, modulo 2^PC_WIDTH; 2^PC_WIDTH-1 wraps to 0.
REQ-018 PCHold SHALL be ignored in stages 0-2.
REQ-019 Handshake SHALL be HandshakeAsync passed through a two-flop synchroniser, giving 2-clock latency.
REQ-020 During a hold, the stage-3 exit SHALL occur on the first clock at which PCHold is sampled 0.

Reset
REQ-021 On nReset=0, the block SHALL immediately force PC=0, Stage=0, IR=0, both synchroniser flops=0 and Handshake=0, regardless of clk.
REQ-022 Reset asserted mid-hold or mid-stage SHALL abandon the current instruction; after release, fetch SHALL restart at address 0 in stage 0 on the first clock edge.

Configuration
REQ-023 Macro FETCH_BRANCH_EN SHALL gate relative branching.
REQ-024 With FETCH_BRANCH_EN defined: at a stage-3 exit with Branch=1, PC SHALL become PC + sign-extended BranchOffset, modulo 2^PC_WIDTH.
REQ-025 With FETCH_BRANCH_EN defined, PCHold=1 SHALL take priority over Branch, and a held branch is taken on the exit cycle if Branch is still 1.
REQ-026 Without FETCH_BRANCH_EN, the Branch and BranchOffset ports SHALL be absent and PC SHALL only increment.

Structure
REQ-027 Shared package picomips_pkg SHALL hold: the stage enum (STG_FETCH=0, STG_DECODE=1, STG_READ=2, STG_EXEC=3), INSTR_W=12, default PC width, and the NOP constant (all zeros).
REQ-028 The handshake synchroniser SHALL be a sub-module named sync2, with a single-bit, reset-to-0 two-flop chain.
REQ-029 No other sub-modules SHALL be used; the ROM is external.

Verification
REQ-030 Reset, then ROM[0]=12'h0A5 and ROM[1]=12'h123, 8 clocks free-running -> Stage 0,1,2,3,0,1,2,3; Instruction=12'h0A5 from clock 1; RomAddr=1 after clock 4; Instruction=12'h123 from clock 5.
REQ-031 PCHold=1 for 5 clocks entering stage 3 at PC=4 -> Stage held at 3 and PC held at 4 for those 5 clocks; PC=5 and Stage=0 one clock after PCHold falls.
REQ-032 PC=8'hFF, PCHold=0 through stage 3 -> PC=8'h00 and Instruction loaded from ROM[0].
REQ-033 HandshakeAsync 0->1 -> Handshake=1 exactly 2 clocks later, and 0 before that.
REQ-034 nReset pulsed low in stage 2 at PC=7 -> PC=0, Stage=0 and Instruction=0 immediately, without a clock edge.
REQ-035 With FETCH_BRANCH_EN: PC=10, BranchOffset=8'hFD, Branch=1 at stage-3 exit -> PC=7; with PCHold=1 simultaneously -> PC stays 10.

Source files
------------

// File: rtl/picomips_pkg.sv
// ============================================================================
//  Module   : picomips_pkg
//  Purpose  : Definitions shared by the picoMIPS fetch path. It holds the
//             stage encoding, the instruction word width, the default
//             program-counter width and the NOP instruction word.
//  Revision : 1.0 - first release
// ============================================================================
`default_nettype none

package picomips_pkg;

    localparam int INSTR_W      = 12;
    localparam int PC_W_DEFAULT = 8;

    localparam logic [INSTR_W-1:0] NOP = '0;

    // One instruction takes four clocks. The encoding is visible on the
    // Stage port, so the numeric values are fixed.
    typedef enum logic [1:0] {
        STG_FETCH  = 2'd0,
        STG_DECODE = 2'd1,
        STG_READ   = 2'd2,
        STG_EXEC   = 2'd3
    } stage_e;

endpackage : picomips_pkg

`default_nettype wire

// File: rtl/sync2.sv
// ============================================================================
//  Module   : sync2
//  Purpose  : Two-flop synchroniser for one bit. It brings an asynchronous
//             level into the clk domain. Both flops reset to 0.
//  Ports    : clk   - destination clock
//             rst_n - asynchronous active-low reset
//             i_d   - unsynchronised input
//             o_q   - synchronised output (2-clock latency)
//  Revision : 1.0 - first release
// ============================================================================
`default_nettype none

module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync2

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch for the picoMIPS core. Each instruction runs
//             through four stages: FETCH, DECODE, READ and EXEC. The unit
//             loads the IR at the end of FETCH. It advances the PC at the
//             end of EXEC, and the control stage can hold EXEC with PCHold.
//  Ports    : clk            - system clock (rising edge)
//             nReset         - asynchronous active-low reset
//             RomAddr        - program ROM address (the PC)
//             RomData        - combinational ROM read data
//             PCHold         - hold request, only looked at in EXEC
//             HandshakeAsync - external handshake, unsynchronised
//             Handshake      - synchronised handshake
//             Instruction    - instruction register
//             Stage          - current stage (0..3)
//             Branch         - relative branch request   (FETCH_BRANCH_EN)
//             BranchOffset   - signed 8-bit branch offset (FETCH_BRANCH_EN)
//  Config   : define FETCH_BRANCH_EN to enable relative branching. Without
//             it the PC only increments, and the Branch and BranchOffset
//             ports do not exist.
//  Revision : 1.0 - first release
// ============================================================================
`default_nettype none

module fetch_unit
    import picomips_pkg::*;
#(
    parameter int PC_WIDTH    = PC_W_DEFAULT,
    parameter int INSTR_WIDTH = INSTR_W
) (
    input  logic                   clk,
    input  logic                   nReset,
    output logic [PC_WIDTH-1:0]    RomAddr,
    input  logic [INSTR_WIDTH-1:0] RomData,
    input  logic                   PCHold,
    input  logic                   HandshakeAsync,
    output logic                   Handshake,
    output logic [INSTR_WIDTH-1:0] Instruction,
    output logic [1:0]             Stage
`ifdef FETCH_BRANCH_EN
    ,
    input  logic                   Branch,
    input  logic [7:0]             BranchOffset
`endif
);

    localparam logic [PC_WIDTH-1:0] c_PC_ONE = PC_WIDTH'(1);

    stage_e                 r_stage;
    logic [PC_WIDTH-1:0]    r_pc;
    logic [INSTR_WIDTH-1:0] r_ir;
    logic [PC_WIDTH-1:0]    w_pc_next;

`ifdef FETCH_BRANCH_EN
    logic [PC_WIDTH-1:0]    w_offset_ext;

    // Sign-extend, or truncate, the 8-bit offset to PC width. The add
    // below then wraps modulo 2^PC_WIDTH.
    always_comb begin
        w_offset_ext = '0;
        for (int i = 0; i < PC_WIDTH; i++) begin
            w_offset_ext[i] = BranchOffset[(i < 8) ? i : 7];
        end
    end

    always_comb begin
        w_pc_next = r_pc + c_PC_ONE;
        if (Branch) begin
            w_pc_next = r_pc + w_offset_ext;
        end
    end
`else
    always_comb begin
        w_pc_next = r_pc + c_PC_ONE;
    end
`endif

    // The PC and IR change only at the FETCH and EXEC boundaries. A hold
    // in EXEC freezes everything. The exit happens on the first edge that
    // samples PCHold=0, so a branch request is taken at that same edge.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_stage <= STG_FETCH;
            r_pc    <= '0;
            r_ir    <= INSTR_WIDTH'(NOP);
        end else begin
            case (r_stage)
                STG_FETCH: begin
                    r_ir    <= RomData;
                    r_stage <= STG_DECODE;
                end
                STG_DECODE: r_stage <= STG_READ;
                STG_READ:   r_stage <= STG_EXEC;
                STG_EXEC: begin
                    if (!PCHold) begin
                        r_pc    <= w_pc_next;
                        r_stage <= STG_FETCH;
                    end
                end
                default:    r_stage <= STG_FETCH;
            endcase
        end
    end

    sync2 u_sync2 (
        .clk   (clk),
        .rst_n (nReset),
        .i_d   (HandshakeAsync),
        .o_q   (Handshake)
    );

    assign RomAddr     = r_pc;
    assign Instruction = r_ir;
    assign Stage       = r_stage;

endmodule : fetch_unit

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking testbench for fetch_unit. It uses a table of
//             directed vectors plus hand-written multi-cycle sequences
//             for wrap, asynchronous reset and (optionally) branching.
//  Revision : 1.0 - first release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk;
    logic        nReset;
    logic [7:0]  RomAddr;
    logic [11:0] RomData;
    logic        PCHold;
    logic        HandshakeAsync;
    logic        Handshake;
    logic [11:0] Instruction;
    logic [1:0]  Stage;
`ifdef FETCH_BRANCH_EN
    logic        Branch;
    logic [7:0]  BranchOffset;
`endif

    logic [11:0] rom [256];
    int checks;
    int errors;

    fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(12)) dut (
        .clk            (clk),
        .nReset         (nReset),
        .RomAddr        (RomAddr),
        .RomData        (RomData),
        .PCHold         (PCHold),
        .HandshakeAsync (HandshakeAsync),
        .Handshake      (Handshake),
        .Instruction    (Instruction),
        .Stage          (Stage)
`ifdef FETCH_BRANCH_EN
        ,
        .Branch         (Branch),
        .BranchOffset   (BranchOffset)
`endif
    );

    assign RomData = rom[RomAddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hold;
        logic        hs_in;
        logic [1:0]  exp_stage;
        logic [7:0]  exp_addr;
        logic [11:0] exp_instr;
        logic        exp_hs;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic h, input logic hs, input logic [1:0] st,
                       input logic [7:0] a, input logic [11:0] ins,
                       input logic ehs);
        vec_t v;
        v.hold = h; v.hs_in = hs; v.exp_stage = st;
        v.exp_addr = a; v.exp_instr = ins; v.exp_hs = ehs;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nReset = 1'b0;
        #2;
        nReset = 1'b1;
        #1;
    endtask

    initial begin
        nReset = 1'b0;
        PCHold = 1'b0;
        HandshakeAsync = 1'b0;
`ifdef FETCH_BRANCH_EN
        Branch = 1'b0;
        BranchOffset = 8'h00;
`endif
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) rom[i] = 12'h800 | 12'(i);
        rom[0] = 12'h0A5;
        rom[1] = 12'h123;

        // hold, hs_in -> stage, addr, instr, handshake (after this edge)
        add(1, 0, 1, 0, 12'h0A5, 0);   // hold ignored in FETCH
        add(1, 0, 2, 0, 12'h0A5, 0);   // hold ignored in DECODE
        add(0, 1, 3, 0, 12'h0A5, 0);   // handshake input rises
        add(0, 1, 0, 1, 12'h0A5, 1);   // two edges later
        add(0, 1, 1, 1, 12'h123, 1);
        add(0, 1, 2, 1, 12'h123, 1);
        add(0, 1, 3, 1, 12'h123, 1);
        add(0, 1, 0, 2, 12'h123, 1);
        add(0, 1, 1, 2, 12'h802, 1);
        add(0, 1, 2, 2, 12'h802, 1);
        add(0, 1, 3, 2, 12'h802, 1);
        add(0, 1, 0, 3, 12'h802, 1);
        add(0, 1, 1, 3, 12'h803, 1);
        add(0, 1, 2, 3, 12'h803, 1);
        add(0, 1, 3, 3, 12'h803, 1);
        add(0, 1, 0, 4, 12'h803, 1);
        add(0, 1, 1, 4, 12'h804, 1);
        add(0, 1, 2, 4, 12'h804, 1);
        add(0, 1, 3, 4, 12'h804, 1);   // EXEC at PC=4
        for (int i = 0; i < 5; i++)
            add(1, 1, 3, 4, 12'h804, 1);  // five held clocks
        add(0, 1, 0, 5, 12'h804, 1);   // exit once hold drops
        add(0, 1, 1, 5, 12'h805, 1);

        // Reset state is checked while reset is still held asserted.
        #12;
        chk("reset_stage", 32'(Stage), 32'd0);
        chk("reset_addr", 32'(RomAddr), 32'd0);
        chk("reset_instr", 32'(Instruction), 32'd0);
        chk("reset_hs", 32'(Handshake), 32'd0);
        @(negedge clk);
        nReset = 1'b1;

        foreach (vecs[i]) begin
            PCHold = vecs[i].hold;
            HandshakeAsync = vecs[i].hs_in;
            tick();
            chk($sformatf("vec%0d_stage", i), 32'(Stage), 32'(vecs[i].exp_stage));
            chk($sformatf("vec%0d_addr", i), 32'(RomAddr), 32'(vecs[i].exp_addr));
            chk($sformatf("vec%0d_instr", i), 32'(Instruction), 32'(vecs[i].exp_instr));
            chk($sformatf("vec%0d_hs", i), 32'(Handshake), 32'(vecs[i].exp_hs));
        end
        PCHold = 1'b0;
        HandshakeAsync = 1'b0;

        // PC wrap from 8'hFF back to 0.
        do_reset();
        repeat (1020) tick();
        chk("wrap_pre_addr", 32'(RomAddr), 32'hFF);
        chk("wrap_pre_stage", 32'(Stage), 32'd0);
        tick();
        chk("wrap_ff_instr", 32'(Instruction), 32'h8FF);
        repeat (3) tick();
        chk("wrap_addr", 32'(RomAddr), 32'h00);
        chk("wrap_stage", 32'(Stage), 32'd0);
        tick();
        chk("wrap_instr", 32'(Instruction), 32'h0A5);

        // Asynchronous reset in READ at PC=7, with the handshake high.
        do_reset();
        HandshakeAsync = 1'b1;
        repeat (30) tick();
        chk("ar_pre_addr", 32'(RomAddr), 32'd7);
        chk("ar_pre_stage", 32'(Stage), 32'd2);
        chk("ar_pre_hs", 32'(Handshake), 32'd1);
        #2;
        nReset = 1'b0;
        #1;
        chk("ar_addr", 32'(RomAddr), 32'd0);
        chk("ar_stage", 32'(Stage), 32'd0);
        chk("ar_instr", 32'(Instruction), 32'd0);
        chk("ar_hs", 32'(Handshake), 32'd0);
        HandshakeAsync = 1'b0;
        #2;
        nReset = 1'b1;
        tick();
        chk("ar_restart_stage", 32'(Stage), 32'd1);
        chk("ar_restart_addr", 32'(RomAddr), 32'd0);
        chk("ar_restart_instr", 32'(Instruction), 32'h0A5);

`ifdef FETCH_BRANCH_EN
        // Branch from PC=10 by -3, first held for one clock.
        do_reset();
        repeat (43) tick();
        chk("br_pre_addr", 32'(RomAddr), 32'd10);
        chk("br_pre_stage", 32'(Stage), 32'd3);
        Branch = 1'b1;
        BranchOffset = 8'hFD;
        PCHold = 1'b1;
        tick();
        chk("br_hold_addr", 32'(RomAddr), 32'd10);
        chk("br_hold_stage", 32'(Stage), 32'd3);
        PCHold = 1'b0;
        tick();
        chk("br_addr", 32'(RomAddr), 32'd7);
        chk("br_stage", 32'(Stage), 32'd0);
        Branch = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fetch_unit

`default_nettype wire
